sram_like_arb: RTL and testbench

- Two-master to one-slave arbiter for the SRAM-like bus. Shares the single data-side SRAM-like port of the AXI bridge between two requesters: m0 is the CPU data port and m1 is a secondary data client such as a DMA or debug port.
- Arbitrates each request (round-robin by default) and tracks outstanding transactions in order, so each data_ok and its rdata are returned to the master that issued the request.

---
 rtl/sram_like_arb.sv | 108 ++++++++++
 tb/tb_sram_like_arb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arb.sv
// sram_like_arb: two-master to one-slave SRAM-like arbiter with in-order response routing.
// Define SRAM_ARB_FIXED_PRIO_EN to give m0 fixed priority instead of round-robin.
module sram_like_arb #(
    parameter int OUTST_DEPTH = 4,
    parameter int PTR_W       = 2
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    output logic        err_orphan
);
    localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(OUTST_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [OUTST_DEPTH-1:0] ids;
    logic [PTR_W-1:0]       head, tail;
    logic [PTR_W:0]         count;
    logic                   lock, locked_id, owner, full, push, pop;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign owner = lock ? locked_id : (!m0_req && m1_req);
`else
    logic rr_ptr;
    assign owner = lock ? locked_id : (m0_req && m1_req) ? rr_ptr : (!m0_req && m1_req);
`endif

    assign full       = count == FULL;
    assign s_req      = !rst && (owner ? m1_req : m0_req) && !full;
    assign s_wr       = owner ? m1_wr    : m0_wr;
    assign s_size     = owner ? m1_size  : m0_size;
    assign s_addr     = owner ? m1_addr  : m0_addr;
    assign s_wdata    = owner ? m1_wdata : m0_wdata;
    assign s_wstrb    = owner ? m1_wstrb : m0_wstrb;
    assign push       = s_req && s_addr_ok;
    assign pop        = !rst && s_data_ok && count != '0;
    assign m0_addr_ok = push && !owner;
    assign m1_addr_ok = push && owner;
    assign m0_data_ok = pop && !ids[head];
    assign m1_data_ok = pop && ids[head];
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    // ids holds the issuing master of each outstanding transaction, oldest at head
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            ids        <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            lock       <= 1'b0;
            locked_id  <= 1'b0;
            err_orphan <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            if (push) begin
                ids[tail] <= owner;
                tail      <= tail + PTR_ONE;
            end
            if (pop)
                head <= head + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
            if (s_req && !s_addr_ok) begin
                lock      <= 1'b1;
                locked_id <= owner;
            end else if (s_addr_ok) begin
                lock <= 1'b0;
            end
            if (s_data_ok && count == '0)
                err_orphan <= 1'b1;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            if (push)
                rr_ptr <= !owner;
`endif
        end
    end
endmodule

// File: tb/tb_sram_like_arb.sv
// tb_sram_like_arb: directed and random checks of sram_like_arb against a queue-based model.
module tb_sram_like_arb;
    localparam int DEPTH = 4;

    logic aclk = 1'b0;
    logic rst  = 1'b1;
    always #5 aclk = ~aclk;

    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_addr_ok, s_data_ok, err_orphan;

    sram_like_arb dut (
        .aclk(aclk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .err_orphan(err_orphan)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", n, a, e, $time);
        end
    endtask

    // Model: queue of issuer ids in acceptance order plus arbitration memory
    bit q[$];
    bit rr, lk, lk_id, orph, o, esreq, ea0, ea1, epop, ed0, ed1;

    function automatic bit own();
        if (lk) return lk_id;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        return !m0_req && m1_req;
`else
        if (m0_req && m1_req) return rr;
        return !m0_req && m1_req;
`endif
    endfunction

    function automatic bit m1exp(int k);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return (k % 2) == 0;
`endif
    endfunction

    always @(posedge rst) begin
        q.delete(); rr = 0; lk = 0; lk_id = 0; orph = 0;
    end

    always begin
        @(negedge aclk);
        #2;
        if (rst) begin
            q.delete(); rr = 0; lk = 0; lk_id = 0; orph = 0;
        end
        o     = own();
        esreq = !rst && (o ? m1_req : m0_req) && q.size() != DEPTH;
        ea0   = esreq && s_addr_ok && !o;
        ea1   = esreq && s_addr_ok && o;
        epop  = !rst && s_data_ok && q.size() != 0;
        ed0   = epop && !q[0];
        ed1   = epop && q[0];
        chk("s_req", s_req, esreq);
        chk("s_fields", {s_wr, s_size, s_addr, s_wdata, s_wstrb},
            o ? {m1_wr, m1_size, m1_addr, m1_wdata, m1_wstrb}
              : {m0_wr, m0_size, m0_addr, m0_wdata, m0_wstrb});
        chk("addr_ok", {m1_addr_ok, m0_addr_ok}, {ea1, ea0});
        chk("data_ok", {m1_data_ok, m0_data_ok}, {ed1, ed0});
        chk("rdata", {m1_rdata, m0_rdata}, {s_rdata, s_rdata});
        chk("err_orphan", err_orphan, orph);
        @(posedge aclk);
        if (!rst) begin
            if (s_data_ok && q.size() == 0) orph = 1;
            if (epop) void'(q.pop_front());
            if (esreq && s_addr_ok) begin q.push_back(o); rr = !o; end
            if (esreq && !s_addr_ok) begin lk = 1; lk_id = o; end
            else if (s_addr_ok) lk = 0;
        end
    end

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            m0_req = 0; m1_req = 0; s_addr_ok = 0;
            s_data_ok = q.size() > 0;
        end
        @(negedge aclk);
        s_data_ok = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] gv;
        int n;
        m0_req = 0; m0_wr = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_req = 0; m1_wr = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_rdata = 0; s_addr_ok = 0; s_data_ok = 0;
        m0_req = 1; s_addr_ok = 1;
        #8;
        chk("rst_sreq", s_req, 0);
        chk("rst_aok", m0_addr_ok, 0);
        chk("rst_err", err_orphan, 0);
        @(negedge aclk); rst = 0; m0_req = 0; s_addr_ok = 0;

        // single m0 read
        @(negedge aclk); m0_req = 1; m0_addr = 32'h1000; m0_size = 2; s_addr_ok = 1;
        #3; chk("t1_aok", {m1_addr_ok, m0_addr_ok}, 2'b01); chk("t1_saddr", s_addr, 32'h1000);
        @(negedge aclk); m0_req = 0; s_addr_ok = 0;
        #3; chk("t1_idle_dok", {m1_data_ok, m0_data_ok}, 0);
        @(negedge aclk);
        @(negedge aclk); s_data_ok = 1; s_rdata = 32'hDEADBEEF;
        #3; chk("t1_dok", {m1_data_ok, m0_data_ok}, 2'b01); chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
        @(negedge aclk); s_data_ok = 0;

        // continuous requests from both, data_ok two cycles after each grant
        gv = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge aclk);
            m0_req = 1; m1_req = 1; s_addr_ok = 1; s_data_ok = k >= 2; s_rdata = $urandom;
            m0_addr = k * 4; m1_addr = 32'h100 + k * 4;
            #3;
            gv[k] = m1_addr_ok;
            chk("t2_grant", {m1_addr_ok, m0_addr_ok}, m1exp(k) ? 2'b10 : 2'b01);
            if (k >= 2) chk("t2_route", {m1_data_ok, m0_data_ok}, m1exp(k - 2) ? 2'b10 : 2'b01);
        end
`ifdef SRAM_ARB_FIXED_PRIO_EN
        chk("t2_seq", gv, 12'h000);
`else
        chk("t2_seq", gv, 12'h555);
`endif
        drain();

        // bridge stalls addr_ok while m0 owns the port
        @(negedge aclk); m0_req = 1; m0_addr = 32'hA000; s_addr_ok = 0;
        #3; chk("t3_saddr0", s_addr, 32'hA000);
        @(negedge aclk); m1_req = 1; m1_addr = 32'hB000;
        #3; chk("t3_saddr1", s_addr, 32'hA000); chk("t3_noaok", {m1_addr_ok, m0_addr_ok}, 0);
        @(negedge aclk);
        #3; chk("t3_saddr2", s_addr, 32'hA000);
        @(negedge aclk); s_addr_ok = 1;
        #3; chk("t3_g0", {m1_addr_ok, m0_addr_ok}, 2'b01);
        @(negedge aclk); m0_req = 0;
        #3; chk("t3_g1", {m1_addr_ok, m0_addr_ok}, 2'b10); chk("t3_saddr_m1", s_addr, 32'hB000);
        drain();

        // fill the tracker with no responses
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk); m0_req = 1; m1_req = 1; s_addr_ok = 1; s_data_ok = 0;
            #3; n += int'(m0_addr_ok) + int'(m1_addr_ok);
        end
        chk("t4_grants", n, 4);
        chk("t4_full_sreq", s_req, 0);
        @(negedge aclk); s_data_ok = 1;
        #3; chk("t4_pop_sreq", s_req, 0); chk("t4_pop_dok", m0_data_ok | m1_data_ok, 1);
        @(negedge aclk); s_data_ok = 0;
        #3; chk("t4_refill_sreq", s_req, 1); chk("t4_5th", m0_addr_ok | m1_addr_ok, 1);
        drain();

        // orphan response, then asynchronous reset mid-transfer
        @(negedge aclk); s_data_ok = 1;
        #3; chk("orph_dok", {m1_data_ok, m0_data_ok}, 0);
        @(negedge aclk); s_data_ok = 0;
        #3; chk("orph_err", err_orphan, 1);
        @(negedge aclk); m0_req = 1; m0_addr = 32'hC000; s_addr_ok = 1;
        @(posedge aclk);
        #3; rst = 1; s_data_ok = 1;
        #1;
        chk("arst_err", err_orphan, 0);
        chk("arst_sreq", s_req, 0);
        chk("arst_aok", {m1_addr_ok, m0_addr_ok}, 0);
        chk("arst_dok", {m1_data_ok, m0_data_ok}, 0);
        @(negedge aclk); rst = 0; m0_req = 0; s_addr_ok = 0; s_data_ok = 1;
        #3; chk("post_rst_dok", {m1_data_ok, m0_data_ok}, 0);
        @(negedge aclk); s_data_ok = 0;
        #3; chk("post_rst_err", err_orphan, 1);
        @(negedge aclk); rst = 1;
        @(negedge aclk); rst = 0;

        // random traffic; masters hold each request until accepted
        for (int i = 0; i < 3000; i++) begin
            @(negedge aclk);
            if (!m0_req || ea0) begin
                m0_req = $urandom_range(0, 3) != 0; m0_wr = 1'($urandom_range(0, 1));
                m0_size = 2'($urandom_range(0, 2)); m0_addr = $urandom;
                m0_wdata = $urandom; m0_wstrb = 4'($urandom);
            end
            if (!m1_req || ea1) begin
                m1_req = $urandom_range(0, 2) != 0; m1_wr = 1'($urandom_range(0, 1));
                m1_size = 2'($urandom_range(0, 2)); m1_addr = $urandom;
                m1_wdata = $urandom; m1_wstrb = 4'($urandom);
            end
            s_addr_ok = $urandom_range(0, 3) != 0;
            s_data_ok = q.size() > 0 && $urandom_range(0, 1) == 1;
            s_rdata = $urandom;
        end
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
